// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two data-memory requesters, the arbiter and the shared memory.
interface dmem_arbiter_if #(
  parameter int N = 32,
  parameter int M = 10
);
  logic         a_req;
  logic         a_we;
  logic [M-1:0] a_adrs;
  logic [N-1:0] a_data_w;
  logic         a_ack;
  logic         a_err;

  logic         b_req;
  logic         b_we;
  logic [M-1:0] b_adrs;
  logic [N-1:0] b_data_w;
  logic         b_ack;
  logic         b_err;

  logic [N-1:0] data_r;

  logic [M-1:0] mem_adrs;
  logic [N-1:0] mem_data_w;
  logic         mem_WE;
  logic [N-1:0] mem_data_r;

  // arbiter side
  modport slave (
    input  a_req, a_we, a_adrs, a_data_w,
    input  b_req, b_we, b_adrs, b_data_w,
    input  mem_data_r,
    output a_ack, a_err, b_ack, b_err, data_r,
    output mem_adrs, mem_data_w, mem_WE
  );

  // requesters plus memory side
  modport master (
    output a_req, a_we, a_adrs, a_data_w,
    output b_req, b_we, b_adrs, b_data_w,
    output mem_data_r,
    input  a_ack, a_err, b_ack, b_err, data_r,
    input  mem_adrs, mem_data_w, mem_WE
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for a shared data memory.
// Each transaction is IDLE -> ACCESS -> RESP (3 cycles); misaligned
// accesses complete with err and never write the memory.
//
//   state  | meaning
//   IDLE   | waiting; sample requests, pick winner, latch its command
//   ACCESS | latched command on the memory bus, write strobe if aligned
//   RESP   | ack (and err if misaligned) to the granted requester
module dmem_arbiter #(
  parameter int N = 32,
  parameter int M = 10
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nx;

  // grant_b is both the current grant and the last grant (1 = B)
  logic         grant_b;
  logic         win_b;
  logic         load;
  logic         we_q;
  logic [M-1:0] adrs_q;
  logic [N-1:0] data_w_q;
  logic [N-1:0] data_r_q;
  logic         misaligned;
  logic         mem_we_c;
  logic         a_ack_c;
  logic         b_ack_c;

  assign misaligned = (adrs_q[1:0] != 2'b00);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state, arbitration and strobes
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    win_b    = grant_b;
    mem_we_c = 1'b0;
    a_ack_c  = 1'b0;
    b_ack_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          load     = 1'b1;
          state_nx = ACCESS;
          // on a tie the requester not granted last wins
          win_b    = (bus.a_req && bus.b_req) ? ~grant_b : bus.b_req;
        end
      end
      ACCESS: begin
        state_nx = RESP;
        mem_we_c = we_q && !misaligned;
      end
      RESP: begin
        state_nx = IDLE;
        a_ack_c  = ~grant_b;
        b_ack_c  = grant_b;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // command latch and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_b  <= 1'b1;
      we_q     <= 1'b0;
      adrs_q   <= '0;
      data_w_q <= '0;
      data_r_q <= '0;
    end else begin
      if (load) begin
        grant_b  <= win_b;
        we_q     <= win_b ? bus.b_we     : bus.a_we;
        adrs_q   <= win_b ? bus.b_adrs   : bus.a_adrs;
        data_w_q <= win_b ? bus.b_data_w : bus.a_data_w;
      end
      if (state == ACCESS) begin
        if (misaligned) begin
          data_r_q <= '0;
        end else if (we_q) begin
          data_r_q <= data_w_q;
        end else begin
          data_r_q <= bus.mem_data_r;
        end
      end
    end
  end

  assign bus.mem_adrs   = adrs_q;
  assign bus.mem_data_w = data_w_q;
  assign bus.mem_WE     = mem_we_c;
  assign bus.data_r     = data_r_q;
  assign bus.a_ack      = a_ack_c;
  assign bus.b_ack      = b_ack_c;
  assign bus.a_err      = a_ack_c && misaligned;
  assign bus.b_err      = b_ack_c && misaligned;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of arbitration and memory contents.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.N(32), .M(10)) bus ();

  dmem_arbiter #(.N(32), .M(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // shared memory: 256 words, combinational read, clocked write
  logic [31:0] mem [0:255];

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (bus.mem_WE) begin
      mem[bus.mem_adrs[9:2]] <= bus.mem_data_w;
    end
  end

  assign bus.mem_data_r = mem[bus.mem_adrs[9:2]];

  int total = 0;
  int bad   = 0;

  // reference memory image
  logic [31:0] ref_mem [0:255];

  // requester-side pending commands (index 0 = A, 1 = B)
  logic        pend   [2];
  logic        p_we   [2];
  logic [9:0]  p_adrs [2];
  logic [31:0] p_data [2];
  int          reissue[2];
  bit          rnd_mode;

  // transaction schedule model: ph = cycles into the current transaction
  int          ph;
  int          win;
  int          last;
  logic        cur_we;
  logic [9:0]  cur_adrs;
  logic [31:0] cur_data;
  logic [31:0] exp_data;
  logic [9:0]  hold_adrs;
  logic [31:0] hold_data;
  int          grants[$];
  logic [31:0] rec_data;
  logic        rec_err;
  int          we_cycles;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.a_req    = pend[0];
    bus.a_we     = p_we[0];
    bus.a_adrs   = p_adrs[0];
    bus.a_data_w = p_data[0];
    bus.b_req    = pend[1];
    bus.b_we     = p_we[1];
    bus.b_adrs   = p_adrs[1];
    bus.b_data_w = p_data[1];
  endtask

  task automatic new_txn(input int r, input logic we, input logic [9:0] adrs, input logic [31:0] data);
    pend[r]   = 1'b1;
    p_we[r]   = we;
    p_adrs[r] = adrs;
    p_data[r] = data;
  endtask

  task automatic model_reset();
    pend[0] = 1'b0;  pend[1] = 1'b0;
    reissue[0] = 0;  reissue[1] = 0;
    ph = 0;  win = 0;  last = 1;
    cur_we = 1'b0;  cur_adrs = '0;  cur_data = '0;
    hold_adrs = '0;  hold_data = '0;
    drive();
  endtask

  task automatic reset_checks();
    chk("rst_a_ack", 64'(bus.a_ack), 64'(0));
    chk("rst_b_ack", 64'(bus.b_ack), 64'(0));
    chk("rst_a_err", 64'(bus.a_err), 64'(0));
    chk("rst_b_err", 64'(bus.b_err), 64'(0));
    chk("rst_mem_we", 64'(bus.mem_WE), 64'(0));
    chk("rst_data_r", 64'(bus.data_r), 64'(0));
    chk("rst_mem_adrs", 64'(bus.mem_adrs), 64'(0));
    chk("rst_mem_data_w", 64'(bus.mem_data_w), 64'(0));
  endtask

  // assert reset now, check outputs, hold across one rising edge, release
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // one clock of checking; inputs for the next rising edge are set here
  task automatic step();
    logic mis;
    @(negedge clk);
    mis = (cur_adrs[1:0] != 2'b00);
    chk("a_ack", 64'(bus.a_ack), 64'(ph == 2 && win == 0));
    chk("b_ack", 64'(bus.b_ack), 64'(ph == 2 && win == 1));
    chk("mem_we", 64'(bus.mem_WE), 64'(ph == 1 && cur_we && !mis));
    chk("mem_adrs", 64'(bus.mem_adrs), 64'(hold_adrs));
    chk("mem_data_w", 64'(bus.mem_data_w), 64'(hold_data));
    if (bus.mem_WE) we_cycles++;
    if (ph == 2) begin
      if (win == 0) begin
        chk("a_err", 64'(bus.a_err), 64'(mis));
        chk("b_err_idle", 64'(bus.b_err), 64'(0));
      end else begin
        chk("b_err", 64'(bus.b_err), 64'(mis));
        chk("a_err_idle", 64'(bus.a_err), 64'(0));
      end
      chk("data_r", 64'(bus.data_r), 64'(exp_data));
      rec_data = bus.data_r;
      rec_err  = (win == 0) ? bus.a_err : bus.b_err;
      pend[win] = 1'b0;
      if (reissue[win] > 0) begin
        reissue[win]--;
        new_txn(win, 1'b0, 10'($urandom_range(255) * 4), $urandom);
      end
    end else begin
      chk("a_err_noack", 64'(bus.a_err), 64'(0));
      chk("b_err_noack", 64'(bus.b_err), 64'(0));
    end
    if (rnd_mode) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(2) == 0)
          new_txn(r, 1'($urandom_range(1)), 10'($urandom_range(1023)), $urandom);
      end
    end
    drive();
    case (ph)
      0: begin
        if (pend[0] || pend[1]) begin
          if (pend[0] && pend[1]) win = 1 - last;
          else win = pend[0] ? 0 : 1;
          last = win;
          grants.push_back(win);
          cur_we    = p_we[win];
          cur_adrs  = p_adrs[win];
          cur_data  = p_data[win];
          hold_adrs = cur_adrs;
          hold_data = cur_data;
          ph = 1;
        end
      end
      1: begin
        if (cur_adrs[1:0] != 2'b00) exp_data = '0;
        else if (cur_we) exp_data = cur_data;
        else exp_data = ref_mem[cur_adrs[9:2]];
        if (cur_we && cur_adrs[1:0] == 2'b00) ref_mem[cur_adrs[9:2]] = cur_data;
        ph = 2;
      end
      default: ph = 0;
    endcase
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((pend[0] || pend[1] || ph != 0) && n < budget) begin
      step();
      n++;
    end
    chk("done_within_budget", 64'(pend[0] || pend[1] || ph != 0), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    p_we[0] = 1'b0;  p_adrs[0] = '0;  p_data[0] = '0;
    p_we[1] = 1'b0;  p_adrs[1] = '0;  p_data[1] = '0;
    rnd_mode  = 1'b0;
    we_cycles = 0;
    rec_data  = '0;
    rec_err   = 1'b0;
    mem_init  = 1'b1;
    apply_reset();
    mem_init  = 1'b0;

    // A writes then reads back 0x010
    we_cycles = 0;
    new_txn(0, 1'b1, 10'h010, 32'hDEAD_BEEF);
    wait_done(10);
    chk("wr_we_cycles", 64'(we_cycles), 64'(1));
    new_txn(0, 1'b0, 10'h010, 32'h0);
    wait_done(10);
    chk("rd_010", 64'(rec_data), 64'(32'hDEAD_BEEF));

    // both request together after reset: A,B,A,B
    apply_reset();
    grants.delete();
    new_txn(0, 1'b0, 10'h040, 32'h0);
    new_txn(1, 1'b0, 10'h080, 32'h0);
    reissue[0] = 1;
    reissue[1] = 1;
    wait_done(30);
    chk("rr_count", 64'(grants.size()), 64'(4));
    for (int i = 0; i < grants.size(); i++) chk("rr_order", 64'(grants[i]), 64'(i % 2));

    // misaligned B write, then A reads the untouched word
    we_cycles = 0;
    new_txn(1, 1'b1, 10'h013, 32'h0BAD_F00D);
    wait_done(10);
    chk("mis_err", 64'(rec_err), 64'(1));
    chk("mis_data_r", 64'(rec_data), 64'(0));
    chk("mis_no_we", 64'(we_cycles), 64'(0));
    new_txn(0, 1'b0, 10'h010, 32'h0);
    wait_done(10);
    chk("rd_after_mis", 64'(rec_data), 64'(32'hDEAD_BEEF));

    // reset mid-ACCESS write kills the transaction
    new_txn(0, 1'b1, 10'h020, 32'h1234_5678);
    step();
    @(posedge clk);
    #2;
    chk("access_we_high", 64'(bus.mem_WE), 64'(1));
    apply_reset();
    new_txn(0, 1'b0, 10'h020, 32'h0);
    wait_done(10);
    chk("rst_no_write", 64'(rec_data == 32'h1234_5678), 64'(0));

    // B arrives during A's ACCESS and is served right after
    grants.delete();
    new_txn(0, 1'b0, 10'h100, 32'h0);
    step();
    new_txn(1, 1'b0, 10'h104, 32'h0);
    wait_done(15);
    chk("late_b_count", 64'(grants.size()), 64'(2));
    if (grants.size() == 2) chk("late_b_second", 64'(grants[1]), 64'(1));

    // random traffic
    rnd_mode = 1'b1;
    repeat (400) step();
    rnd_mode = 1'b0;
    wait_done(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001: Parameter N, default 32, data word width in bits.
REQ-002: Parameter M, default 10, byte-address width of the shared data memory.
REQ-003: Port clk input 1: the single clock; all state SHALL update on its rising edge.
REQ-004: Port rst input 1: reset, asynchronous and active-low; asserting it (rst=0) SHALL reset the block immediately, independent of clk.
REQ-005: Ports a_req/b_req input 1: access request from requester A (core load/store) and requester B (DMA/debug).
REQ-006: Ports a_we/b_we input 1: 1 = write, 0 = read.
REQ-007: Ports a_adrs/b_adrs input M: byte address.
REQ-008: Ports a_data_w/b_data_w input N: write data.
REQ-009: Ports a_ack/b_ack output 1: one-cycle completion pulse to the requester.
REQ-010: Ports a_err/b_err output 1: misaligned-access flag, valid only while the matching ack is high.
REQ-011: Port data_r output N: registered read data, valid while either ack is high.
REQ-012: Ports mem_adrs output M, mem_data_w output N, mem_WE output 1: drive the shared memory.
REQ-013: Port mem_data_r input N: combinational read data returned by the memory.

Function
REQ-014: The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-015: IDLE->ACCESS when any request is high; the winner SHALL be latched (grant, we, adrs, data_w).
REQ-016: ACCESS->RESP unconditionally after one cycle.
REQ-017: RESP->IDLE unconditionally; every transaction SHALL take exactly 3 cycles from the sampled req to the cycle after ack.
REQ-018: Arbitration SHALL be round-robin.
  - Single request: that requester wins.
  - Simultaneous requests: the requester not granted last wins.
  - last_grant SHALL reset to B, so A wins the first tie.
REQ-019: In ACCESS, mem_adrs SHALL equal the latched adrs and mem_data_w the latched data.
REQ-020: mem_WE SHALL be high only in ACCESS, for a latched aligned write.
REQ-021: In all other states mem_WE=0, and mem_adrs/mem_data_w SHALL hold their last values.
REQ-022: At the end of ACCESS, mem_data_r SHALL be captured into data_r for reads.
  - For writes, data_r SHALL capture the written data.
REQ-023: In RESP, exactly the granted requester's ack SHALL be 1; the other ack SHALL be 0.
REQ-024: Alignment: an access with adrs[1:0]!=0 is misaligned.
  - The write is suppressed (mem_WE stays 0).
  - data_r = 0.
  - The granted err = 1 with ack.
  - The FSM sequence is unchanged.
REQ-025: A requester SHALL hold req, we, adrs and data_w stable until its ack.
  - The block SHALL latch these in IDLE and ignore later changes within the transaction.
REQ-026: A requester that keeps req high in the ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-027: A request arriving during ACCESS/RESP SHALL wait and be arbitrated in the next IDLE.
  - No request SHALL be dropped.
REQ-028: With both requesters continuously active, grants SHALL alternate A,B,A,B.
  - Neither requester SHALL wait more than one transaction.

Reset
REQ-029: While rst=0, the block SHALL hold these values:
  - state = IDLE, last_grant = B.
  - a_ack = b_ack = a_err = b_err = 0.
  - mem_WE = 0, data_r = 0, mem_adrs = 0, mem_data_w = 0.
REQ-030: rst asserted mid-ACCESS SHALL drop mem_WE to 0 immediately; no memory write occurs from that transaction and no ack is issued.
REQ-031: After rst deasserts, the first rising edge with a request high SHALL begin arbitration from IDLE.

Verification
REQ-032: A writes 0xDEADBEEF to 0x010, then A reads 0x010.
  - mem_WE high for exactly one cycle.
  - The read ack returns data_r = 0xDEADBEEF.
  - Each ack arrives 2 cycles after req is sampled.
REQ-033: a_req and b_req rise together after reset and both hold for four transactions.
  - Grant order SHALL be A,B,A,B.
  - No two acks in the same cycle.
REQ-034: B writes to 0x013.
  - b_ack = 1 with b_err = 1.
  - mem_WE never rises.
  - A subsequent read of 0x010 returns its prior value.
REQ-035: rst pulsed low during an ACCESS write of 0x12345678 to 0x020.
  - mem_WE falls immediately and all outputs are 0.
  - A later read of 0x020 does not return 0x12345678.
REQ-036: b_req rises during A's ACCESS cycle.
  - B is granted in the IDLE after A's ack.
  - b_ack follows 2 cycles later.
  - a_ack and b_ack are never high together.
